ref_sample_gen: RTL and testbench
=================================

# ref_sample_gen

Generates the intra-prediction reference samples for one 8x8 block. It consumes the 17 neighbouring pixels serially from the line/column buffers, applies HEVC unavailable-sample substitution, and produces two sets of registered outputs: an unfiltered set for angular prediction and a [1 2 1]-smoothed set for planar prediction. It is the producer feeding the angle/planar reference arbiter, and drives both of that arbiter's input sets.

## Interface
- BIT_DEPTH, 8: sample width; the substitution default is 1<<(BIT_DEPTH-1).
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to begin a new block; accepted only in IDLE or DONE
- pix_valid  in  1  pix_data/pix_avail valid this cycle
- pix_data  in  8  neighbour sample
- pix_avail  in  1  1 = sample available, 0 = unavailable (pix_data ignored)
- pix_ready  out  1  high in LOAD only; a sample transfers when pix_valid && pix_ready
- busy  out  1  high in LOAD, SUBST, FILT
- ref_valid  out  1  outputs below hold a complete, stable result
- REF_TOPi_angle, i=0..7  out  8  unfiltered top samples
- REF_LEFTi_angle, i=0..7  out  8  unfiltered left samples
- REF_CORNER_angle  out  8  unfiltered top-left sample
- REF_TOPi_planar, REF_LEFTi_planar, REF_CORNER_planar  out  8 each  filtered samples

## Operation
- Scan order (index 0..16): LEFT7, LEFT6 … LEFT0, CORNER, TOP0 … TOP7. Samples arrive in this order.
- FSM states: IDLE, LOAD, SUBST, FILT, DONE.
  - IDLE/DONE + start → LOAD. Clears ref_valid and the load counter.
  - LOAD: each transfer stores the sample and its avail flag at the counter index, then increments the counter. The transfer of index 16 → SUBST.
  - SUBST (1 cycle): substitution writes the *_angle registers.
    - → FILT.
    - Without REF_FILTER_EN: also writes the *_planar registers with the same values, then → DONE.
  - FILT (1 cycle) → DONE.
  - DONE: ref_valid=1. Outputs hold until the next SUBST.
- Substitution:
  - No sample available: all 17 = 128.
  - Otherwise, leading unavailable entries (before the first available one in scan order) take the first available value.
  - Every later unavailable entry takes the value of its predecessor in scan order after substitution.
- Filter on the substituted array s[0..16]:
  - p[k] = (s[k-1] + 2*s[k] + s[k+1] + 2) >> 2 for k=1..15.
  - Compute in 10 bits, truncate to 8. No saturation is needed.
  - p[0] = s[0] (LEFT7) and p[16] = s[16] (TOP7) are passed unfiltered.
- start asserted in LOAD/SUBST/FILT is ignored; it does not restart the block.
- pix_valid outside LOAD is ignored.

## Timing
- Reset (asynchronous, any state, including mid-load): state=IDLE, counter=0, pix_ready=0, busy=0, ref_valid=0, every REF_* output = 0.
- The start edge moves the FSM to LOAD. pix_ready is high from the following cycle.
- pix_valid may deassert for any number of cycles; the counter holds across gaps.
- Let E0 be the edge that accepts index 16.
  - *_angle registers update at E0+1.
  - *_planar registers and ref_valid=1 update at E0+2, or at E0+1 without REF_FILTER_EN.
- Minimum start-to-ref_valid time: 20 edges with the filter, 19 without.
- start in DONE: ref_valid falls on the next edge. Old REF_* values persist until the new SUBST edge.

## Configuration
- REF_FILTER_EN defined:
  - FILT state exists.
  - Planar outputs are the [1 2 1] filtered values.
- REF_FILTER_EN undefined:
  - FILT state and filter logic are removed.
  - Planar outputs equal the angle outputs.
  - Latency is one cycle shorter.

## Test plan
- All 17 samples available with value 100, except TOP3=200 → angle TOP3=200, all other angle outputs 100. Planar TOP2=125, TOP3=150, TOP4=125, all other planar outputs 100. ref_valid rises 2 edges after the last transfer.
- All pix_avail=0 → all 34 outputs = 128.
- Only TOP5 available (=77) → all angle outputs 77, all planar outputs 77.
- LEFT7..LEFT4 unavailable, LEFT3=50, all others available =60, TOP2 unavailable → LEFT7..LEFT4 angle outputs = 50, TOP2 angle = 60. Separately, with TOP1=90 and TOP2 unavailable → TOP2 angle = 90.
- pix_valid toggling every other cycle, plus start pulses during LOAD → exactly 17 transfers are taken and the result matches the gap-free run; ref_valid asserts once.
- rst_n pulled low after 9 transfers → all outputs 0 and state IDLE immediately. A fresh start followed by 17 transfers yields the correct result.

Source files
------------

// File: rtl/ref_sample_gen.sv
// ref_sample_gen
//   Builds the intra-prediction reference samples for one 8x8 block.
//   The 17 neighbours arrive serially in scan order:
//   LEFT7..LEFT0, CORNER, TOP0..TOP7 (index 0..16).
//   Unavailable samples are substituted, and two registered sets are produced:
//   angle  : substituted, unfiltered
//   planar : [1 2 1] smoothed (REF_FILTER_EN), otherwise a copy of angle
//
// Configuration macro: REF_FILTER_EN
//   defined   -> FILT state and the smoothing filter are built, so planar is
//                valid one cycle after angle.
//   undefined -> planar mirrors angle, and the latency is one cycle shorter.
//
// Ports
//   clk, rst_n          : clock, async active-low reset
//   start               : begin a new block (honoured in IDLE/DONE only)
//   pix_valid/pix_data/pix_avail, pix_ready : serial neighbour input
//   busy                : LOAD/SUBST/FILT in progress
//   ref_valid           : REF_* outputs hold a complete result
//   REF_{TOPi,LEFTi,CORNER}_{angle,planar} : reference sample outputs
module ref_sample_gen #(
  parameter int BIT_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 pix_valid,
  input  logic [BIT_DEPTH-1:0] pix_data,
  input  logic                 pix_avail,
  output logic                 pix_ready,
  output logic                 busy,
  output logic                 ref_valid,
  output logic [BIT_DEPTH-1:0] REF_TOP0_angle,   REF_TOP1_angle,   REF_TOP2_angle,
  output logic [BIT_DEPTH-1:0] REF_TOP3_angle,   REF_TOP4_angle,   REF_TOP5_angle,
  output logic [BIT_DEPTH-1:0] REF_TOP6_angle,   REF_TOP7_angle,
  output logic [BIT_DEPTH-1:0] REF_LEFT0_angle,  REF_LEFT1_angle,  REF_LEFT2_angle,
  output logic [BIT_DEPTH-1:0] REF_LEFT3_angle,  REF_LEFT4_angle,  REF_LEFT5_angle,
  output logic [BIT_DEPTH-1:0] REF_LEFT6_angle,  REF_LEFT7_angle,
  output logic [BIT_DEPTH-1:0] REF_CORNER_angle,
  output logic [BIT_DEPTH-1:0] REF_TOP0_planar,  REF_TOP1_planar,  REF_TOP2_planar,
  output logic [BIT_DEPTH-1:0] REF_TOP3_planar,  REF_TOP4_planar,  REF_TOP5_planar,
  output logic [BIT_DEPTH-1:0] REF_TOP6_planar,  REF_TOP7_planar,
  output logic [BIT_DEPTH-1:0] REF_LEFT0_planar, REF_LEFT1_planar, REF_LEFT2_planar,
  output logic [BIT_DEPTH-1:0] REF_LEFT3_planar, REF_LEFT4_planar, REF_LEFT5_planar,
  output logic [BIT_DEPTH-1:0] REF_LEFT6_planar, REF_LEFT7_planar,
  output logic [BIT_DEPTH-1:0] REF_CORNER_planar
);

  localparam int N = 17;
  localparam logic [BIT_DEPTH-1:0] DEF_VAL = {1'b1, {(BIT_DEPTH-1){1'b0}}};

`ifdef REF_FILTER_EN
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SUBST, S_FILT, S_DONE} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SUBST, S_DONE} state_t;
`endif

  state_t               r_state, w_next;
  logic [4:0]           r_cnt;
  logic [BIT_DEPTH-1:0] r_pix  [N];
  logic                 r_avail[N];
  logic [BIT_DEPTH-1:0] r_ang  [N];
  logic [BIT_DEPTH-1:0] r_pla  [N];
  logic [BIT_DEPTH-1:0] w_sub  [N];
  logic                 w_xfer;
  logic                 w_start_ok;

  assign w_xfer     = pix_valid && (r_state == S_LOAD);
  assign w_start_ok = start && ((r_state == S_IDLE) || (r_state == S_DONE));

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    pix_ready = 1'b0;
    busy      = 1'b0;
    ref_valid = 1'b0;
    case (r_state)
      S_IDLE:  if (start) w_next = S_LOAD;
      S_LOAD: begin
        pix_ready = 1'b1;
        busy      = 1'b1;
        if (w_xfer && (r_cnt == 5'd16)) w_next = S_SUBST;
      end
      S_SUBST: begin
        busy = 1'b1;
`ifdef REF_FILTER_EN
        w_next = S_FILT;
`else
        w_next = S_DONE;
`endif
      end
`ifdef REF_FILTER_EN
      S_FILT: begin
        busy   = 1'b1;
        w_next = S_DONE;
      end
`endif
      S_DONE: begin
        ref_valid = 1'b1;
        if (start) w_next = S_LOAD;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // ---------------- substitution ----------------
  // The first available sample seeds the chain, so leading gaps copy it.
  // Every later gap copies whatever was produced for its predecessor.
  always_comb begin
    logic [BIT_DEPTH-1:0] v_first;
    logic [BIT_DEPTH-1:0] v_run;
    v_first = DEF_VAL;
    for (int k = N-1; k >= 0; k--)
      if (r_avail[k]) v_first = r_pix[k];
    v_run = v_first;
    for (int k = 0; k < N; k++) begin
      if (r_avail[k]) v_run = r_pix[k];
      w_sub[k] = v_run;
    end
  end

`ifdef REF_FILTER_EN
  // ---------------- [1 2 1] smoothing ----------------
  // The filter reads the angle registers during FILT.
  // Its endpoints pass through unchanged.
  logic [BIT_DEPTH-1:0] w_flt[N];
  always_comb begin
    logic [BIT_DEPTH+1:0] v_sum;
    v_sum      = '0;
    w_flt[0]   = r_ang[0];
    w_flt[N-1] = r_ang[N-1];
    for (int k = 1; k < N-1; k++) begin
      v_sum = {2'b00, r_ang[k-1]} + {1'b0, r_ang[k], 1'b0} + {2'b00, r_ang[k+1]}
            + (BIT_DEPTH+2)'(2);
      w_flt[k] = v_sum[BIT_DEPTH+1:2];
    end
  end
`endif

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      for (int k = 0; k < N; k++) begin
        r_pix[k]   <= '0;
        r_avail[k] <= 1'b0;
        r_ang[k]   <= '0;
        r_pla[k]   <= '0;
      end
    end else begin
      if (w_start_ok) r_cnt <= '0;
      if (w_xfer) begin
        r_pix[r_cnt]   <= pix_data;
        r_avail[r_cnt] <= pix_avail;
        r_cnt          <= r_cnt + 5'd1;
      end
      if (r_state == S_SUBST) begin
        for (int k = 0; k < N; k++) begin
          r_ang[k] <= w_sub[k];
`ifndef REF_FILTER_EN
          r_pla[k] <= w_sub[k];
`endif
        end
      end
`ifdef REF_FILTER_EN
      if (r_state == S_FILT)
        for (int k = 0; k < N; k++) r_pla[k] <= w_flt[k];
`endif
    end
  end

  // ---------------- output mapping (scan index -> name) ----------------
  assign REF_LEFT7_angle   = r_ang[0];   assign REF_LEFT7_planar  = r_pla[0];
  assign REF_LEFT6_angle   = r_ang[1];   assign REF_LEFT6_planar  = r_pla[1];
  assign REF_LEFT5_angle   = r_ang[2];   assign REF_LEFT5_planar  = r_pla[2];
  assign REF_LEFT4_angle   = r_ang[3];   assign REF_LEFT4_planar  = r_pla[3];
  assign REF_LEFT3_angle   = r_ang[4];   assign REF_LEFT3_planar  = r_pla[4];
  assign REF_LEFT2_angle   = r_ang[5];   assign REF_LEFT2_planar  = r_pla[5];
  assign REF_LEFT1_angle   = r_ang[6];   assign REF_LEFT1_planar  = r_pla[6];
  assign REF_LEFT0_angle   = r_ang[7];   assign REF_LEFT0_planar  = r_pla[7];
  assign REF_CORNER_angle  = r_ang[8];   assign REF_CORNER_planar = r_pla[8];
  assign REF_TOP0_angle    = r_ang[9];   assign REF_TOP0_planar   = r_pla[9];
  assign REF_TOP1_angle    = r_ang[10];  assign REF_TOP1_planar   = r_pla[10];
  assign REF_TOP2_angle    = r_ang[11];  assign REF_TOP2_planar   = r_pla[11];
  assign REF_TOP3_angle    = r_ang[12];  assign REF_TOP3_planar   = r_pla[12];
  assign REF_TOP4_angle    = r_ang[13];  assign REF_TOP4_planar   = r_pla[13];
  assign REF_TOP5_angle    = r_ang[14];  assign REF_TOP5_planar   = r_pla[14];
  assign REF_TOP6_angle    = r_ang[15];  assign REF_TOP6_planar   = r_pla[15];
  assign REF_TOP7_angle    = r_ang[16];  assign REF_TOP7_planar   = r_pla[16];

endmodule

// File: tb/tb_ref_sample_gen.sv
module tb_ref_sample_gen;

`ifdef REF_FILTER_EN
  localparam int LAT  = 2;
  localparam bit FILT = 1'b1;
`else
  localparam int LAT  = 1;
  localparam bit FILT = 1'b0;
`endif

  typedef logic [7:0] vec_t [17];
  typedef bit         flg_t [17];

  logic       clk = 1'b0;
  logic       rst_n, start, pix_valid, pix_avail;
  logic [7:0] pix_data;
  logic       pix_ready, busy, ref_valid;
  logic [7:0] ang [17];
  logic [7:0] pla [17];

  int   checks = 0, failures = 0;
  vec_t cur_d, exp_s, exp_p;
  flg_t cur_a;
  bit   have_prev;

  always #5 clk = ~clk;

  ref_sample_gen #(.BIT_DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pix_valid(pix_valid),
    .pix_data(pix_data), .pix_avail(pix_avail), .pix_ready(pix_ready),
    .busy(busy), .ref_valid(ref_valid),
    .REF_LEFT7_angle(ang[0]),  .REF_LEFT6_angle(ang[1]),  .REF_LEFT5_angle(ang[2]),
    .REF_LEFT4_angle(ang[3]),  .REF_LEFT3_angle(ang[4]),  .REF_LEFT2_angle(ang[5]),
    .REF_LEFT1_angle(ang[6]),  .REF_LEFT0_angle(ang[7]),  .REF_CORNER_angle(ang[8]),
    .REF_TOP0_angle(ang[9]),   .REF_TOP1_angle(ang[10]),  .REF_TOP2_angle(ang[11]),
    .REF_TOP3_angle(ang[12]),  .REF_TOP4_angle(ang[13]),  .REF_TOP5_angle(ang[14]),
    .REF_TOP6_angle(ang[15]),  .REF_TOP7_angle(ang[16]),
    .REF_LEFT7_planar(pla[0]), .REF_LEFT6_planar(pla[1]), .REF_LEFT5_planar(pla[2]),
    .REF_LEFT4_planar(pla[3]), .REF_LEFT3_planar(pla[4]), .REF_LEFT2_planar(pla[5]),
    .REF_LEFT1_planar(pla[6]), .REF_LEFT0_planar(pla[7]), .REF_CORNER_planar(pla[8]),
    .REF_TOP0_planar(pla[9]),  .REF_TOP1_planar(pla[10]), .REF_TOP2_planar(pla[11]),
    .REF_TOP3_planar(pla[12]), .REF_TOP4_planar(pla[13]), .REF_TOP5_planar(pla[14]),
    .REF_TOP6_planar(pla[15]), .REF_TOP7_planar(pla[16])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Reference model: each sample takes the nearest available sample at or
  // before it in scan order, or the first available one if none precedes it.
  // With nothing available, every sample is the mid-grey default.
  task automatic model(input vec_t d, input flg_t a, output vec_t s, output vec_t p);
    int first;
    int j;
    first = -1;
    for (int k = 16; k >= 0; k--) if (a[k]) first = k;
    for (int k = 0; k < 17; k++) begin
      if (first < 0) s[k] = 8'd128;
      else begin
        j = k;
        while (j >= 0 && !a[j]) j--;
        s[k] = (j >= 0) ? d[j] : d[first];
      end
    end
    for (int k = 0; k < 17; k++) begin
      if (!FILT || k == 0 || k == 16) p[k] = s[k];
      else p[k] = 8'((int'(s[k-1]) + 2 * int'(s[k]) + int'(s[k+1]) + 2) / 4);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ready"}, pix_ready, 0);
    chk({tag, "_busy"},  busy, 0);
    chk({tag, "_valid"}, ref_valid, 0);
    for (int k = 0; k < 17; k++) begin
      chk($sformatf("%s_ang%0d", tag, k), ang[k], 0);
      chk($sformatf("%s_pla%0d", tag, k), pla[k], 0);
    end
  endtask

  // mode 0: continuous pix_valid; mode 1: pix_valid every other cycle plus
  // start pulses during LOAD and just after the last transfer.
  task automatic run_block(input int mode);
    int  idx, cyc, n;
    bit  v;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("load_ready", pix_ready, 1);
    chk("load_busy", busy, 1);
    chk("load_valid_low", ref_valid, 0);
    if (have_prev)  // old results persist until the new SUBST
      for (int k = 0; k < 17; k++) chk($sformatf("hold_ang%0d", k), ang[k], exp_s[k]);
    idx = 0;
    cyc = 0;
    while (idx < 17 && cyc < 200) begin
      v = (mode == 0) || (cyc % 2 == 0);
      pix_valid = v;
      pix_data  = v ? cur_d[idx] : 8'($urandom);
      pix_avail = v ? cur_a[idx] : 1'($urandom);
      start     = (mode == 1) && (cyc % 3 == 1);
      if (v && pix_ready) idx++;
      @(negedge clk);
      cyc++;
    end
    chk("xfer_count", idx, 17);
    // Now in SUBST: a stray transfer and start must be ignored.
    pix_valid = 1'b1;
    pix_data  = 8'hEE;
    pix_avail = 1'b1;
    start     = (mode == 1);
    n = 0;
    while (ref_valid !== 1'b1 && n < 10) begin
      chk("busy_wait", busy, 1);
      @(negedge clk);
      pix_valid = 1'b0;
      start     = 1'b0;
      n++;
    end
    chk("latency", n, LAT);
    model(cur_d, cur_a, exp_s, exp_p);
    for (int k = 0; k < 17; k++) begin
      chk($sformatf("ang%0d", k), ang[k], exp_s[k]);
      chk($sformatf("pla%0d", k), pla[k], exp_p[k]);
    end
    chk("done_busy", busy, 0);
    chk("done_ready", pix_ready, 0);
    repeat (3) @(negedge clk);
    chk("valid_holds", ref_valid, 1);
    have_prev = 1'b1;
  endtask

  task automatic fill(input logic [7:0] val, input bit av);
    for (int k = 0; k < 17; k++) begin
      cur_d[k] = val;
      cur_a[k] = av;
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; pix_valid = 1'b0; pix_data = '0; pix_avail = 1'b0;
    have_prev = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // all 100 except TOP3=200
    fill(8'd100, 1'b1);
    cur_d[12] = 8'd200;
    run_block(0);
    chk("tp1_top3", ang[12], 200);
    chk("tp1_left7", ang[0], 100);

    // nothing available
    for (int k = 0; k < 17; k++) begin
      cur_d[k] = 8'($urandom);
      cur_a[k] = 1'b0;
    end
    run_block(0);
    chk("tp2_left2", ang[5], 128);
    chk("tp2_pla_corner", pla[8], 128);

    // only TOP5 available
    fill(8'd3, 1'b0);
    cur_d[14] = 8'd77;
    cur_a[14] = 1'b1;
    run_block(0);
    chk("tp3_left7", ang[0], 77);
    chk("tp3_pla_top7", pla[16], 77);

    // leading gap and a later gap
    fill(8'd60, 1'b1);
    for (int k = 0; k < 4; k++) cur_a[k] = 1'b0;
    cur_d[4]  = 8'd50;
    cur_a[11] = 1'b0;
    cur_d[11] = 8'd9;
    run_block(0);
    chk("tp4_left7", ang[0], 50);
    chk("tp4_left4", ang[3], 50);
    chk("tp4_top2", ang[11], 60);
    cur_d[10] = 8'd90;
    run_block(0);
    chk("tp4b_top2", ang[11], 90);

    // same random block gap-free and with gaps/start pulses
    for (int k = 0; k < 17; k++) begin
      cur_d[k] = 8'($urandom);
      cur_a[k] = ($urandom_range(0, 3) != 0);
    end
    run_block(0);
    run_block(1);

    // random blocks, varying availability density
    for (int t = 0; t < 6; t++) begin
      for (int k = 0; k < 17; k++) begin
        cur_d[k] = 8'($urandom);
        cur_a[k] = ($urandom_range(0, 5) < t);
      end
      run_block(t % 2);
    end

    // reset after 9 transfers
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 9; k++) begin
      pix_valid = 1'b1;
      pix_data  = 8'($urandom);
      pix_avail = 1'b1;
      @(negedge clk);
    end
    pix_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    have_prev = 1'b0;
    for (int k = 0; k < 17; k++) begin
      cur_d[k] = 8'($urandom);
      cur_a[k] = ($urandom_range(0, 2) != 0);
    end
    run_block(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
